// File: rtl/trigger_word_receiver_pkg.sv
// Shared definitions for the trigger word link: default word width,
// FSM state encodings and a leading-zero helper. Both the receive and
// transmit sides of the link import this package.
package trigger_word_receiver_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int WINDOW_BITS   = 2 * DEFAULT_WIDTH;

    // Receiver FSM encodings; the transmit side relies on the same values.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLDOFF = 2'd2
    } rx_state_t;

    // Number of zeros ahead of the first one, counting from bit 7
    // (the earliest bit on the line). An all-zero word returns 7.
    function automatic logic [2:0] leading_zeros8(input logic [7:0] w);
        logic [2:0] n;
        logic       found;
        n     = 3'd7;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found && w[i]) begin
                n     = 3'(7 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/pulse_window_decoder.sv
// Combinational classifier for a two-word window. The pulse must start
// exactly at the given offset, be one contiguous run of 1..8 ones, and
// every other bit of the window must be zero.
module pulse_window_decoder
    import trigger_word_receiver_pkg::*;
(
    input  logic [WINDOW_BITS-1:0] window,
    input  logic [2:0]             offset,
    output logic [3:0]             width,
    output logic                   well_formed
);

    logic [WINDOW_BITS-1:0] shifted;
    logic [WINDOW_BITS-1:0] lead_mask;
    logic [WINDOW_BITS-1:0] rest;
    logic [4:0]             run;
    logic                   in_run;

    // Align the leading edge to the MSB, measure the run, then require silence elsewhere
    always_comb begin
        shifted   = window << offset;
        lead_mask = ~(16'hFFFF >> offset);
        run       = 5'd0;
        in_run    = 1'b1;
        for (int i = WINDOW_BITS - 1; i >= 0; i--) begin
            if (in_run && shifted[i]) begin
                run = run + 5'd1;
            end else begin
                in_run = 1'b0;
            end
        end
        rest        = shifted << run;
        well_formed = (run != 5'd0) && (run <= 5'd8) && (rest == '0)
                      && ((window & lead_mask) == '0);
        width       = (run <= 5'd8) ? run[3:0] : 4'd0;
    end

endmodule

// File: rtl/trigger_word_receiver.sv
// Trigger word receiver: finds a single pulse spread over up to two
// deserialized words, reports its width and bit offset, enforces a
// quiet holdoff after each pulse and steers the deserializer towards
// offset 0 with bitslip requests.
module trigger_word_receiver
    import trigger_word_receiver_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HOLDOFF     = 4,
    parameter int ALIGN_COUNT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             trigger,
    output logic [3:0]       trigger_width,
    output logic [2:0]       trigger_offset,
    output logic             malformed,
    output logic             bitslip,
    output logic             aligned,
    output logic [15:0]      trigger_count,
    output logic [15:0]      error_count
);

    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int SCW = $clog2(ALIGN_COUNT + 1);
    localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLDOFF - 1);
    localparam logic [SCW-1:0] ALIGN_LAST = SCW'(ALIGN_COUNT);

    rx_state_t              state;
    logic [WIDTH-1:0]       a_word;
    logic [2:0]             a_offset;
    logic [HCW-1:0]         hold_count;
    logic [SCW-1:0]         streak;
    logic [SCW-1:0]         next_streak;
    logic [2:0]             prev_offset;
    logic                   align_pending;
    logic [2*WIDTH-1:0]     window;
    logic [3:0]             dec_width;
    logic                   dec_ok;

    // The incoming word is B; it is evaluated on the edge that accepts it
    assign window = {a_word, word_in};

    pulse_window_decoder u_decoder (
        .window      (window),
        .offset      (a_offset),
        .width       (dec_width),
        .well_formed (dec_ok)
    );

    // Streak value the current pulse would produce if it turns out well-formed
    always_comb begin
        next_streak = SCW'(1);
        if (a_offset == prev_offset) begin
            next_streak = (streak == ALIGN_LAST) ? streak : streak + SCW'(1);
        end
    end

    // Main FSM: capture, classify, holdoff, plus counters and alignment tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            a_word         <= '0;
            a_offset       <= 3'd0;
            hold_count     <= '0;
            streak         <= '0;
            prev_offset    <= 3'd0;
            align_pending  <= 1'b0;
            trigger        <= 1'b0;
            trigger_width  <= 4'd0;
            trigger_offset <= 3'd0;
            malformed      <= 1'b0;
            bitslip        <= 1'b0;
            aligned        <= 1'b0;
            trigger_count  <= 16'd0;
            error_count    <= 16'd0;
        end else begin
            trigger       <= 1'b0;
            malformed     <= 1'b0;
            bitslip       <= 1'b0;
            align_pending <= 1'b0;
            if (align_pending) begin
                aligned <= 1'b1;
            end
            if (word_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (word_in != '0) begin
                            a_word   <= word_in;
                            a_offset <= leading_zeros8(word_in);
                            state    <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        state      <= ST_HOLDOFF;
                        hold_count <= '0;
                        if (dec_ok) begin
                            trigger        <= 1'b1;
                            trigger_width  <= dec_width;
                            trigger_offset <= a_offset;
                            prev_offset    <= a_offset;
                            if (trigger_count != 16'hFFFF) begin
                                trigger_count <= trigger_count + 16'd1;
                            end
                            if (next_streak == ALIGN_LAST && a_offset != 3'd0) begin
                                bitslip <= 1'b1;
                                streak  <= '0;
                            end else begin
                                streak <= next_streak;
                                if (next_streak == ALIGN_LAST) begin
                                    align_pending <= 1'b1;
                                end
                            end
                            if (a_offset != 3'd0) begin
                                aligned <= 1'b0;
                            end
                        end else begin
                            malformed <= 1'b1;
                            streak    <= '0;
                            aligned   <= 1'b0;
                            if (error_count != 16'hFFFF) begin
                                error_count <= error_count + 16'd1;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (word_in == '0) begin
                            if (hold_count == HOLD_LAST) begin
                                state      <= ST_IDLE;
                                hold_count <= '0;
                            end else begin
                                hold_count <= hold_count + HCW'(1);
                            end
                        end else begin
                            malformed  <= 1'b1;
                            hold_count <= '0;
                            streak     <= '0;
                            aligned    <= 1'b0;
                            if (error_count != 16'hFFFF) begin
                                error_count <= error_count + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_word_receiver.sv
// Directed self-checking bench for trigger_word_receiver.
module tb_trigger_word_receiver;

    logic        clock;
    logic        reset;
    logic [7:0]  word_in;
    logic        word_valid;
    logic        trigger;
    logic [3:0]  trigger_width;
    logic [2:0]  trigger_offset;
    logic        malformed;
    logic        bitslip;
    logic        aligned;
    logic [15:0] trigger_count;
    logic [15:0] error_count;

    int checks = 0;
    int errors = 0;

    trigger_word_receiver #(
        .WIDTH       (8),
        .HOLDOFF     (4),
        .ALIGN_COUNT (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .trigger        (trigger),
        .trigger_width  (trigger_width),
        .trigger_offset (trigger_offset),
        .malformed      (malformed),
        .bitslip        (bitslip),
        .aligned        (aligned),
        .trigger_count  (trigger_count),
        .error_count    (error_count)
    );

    // Free-running word clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one word on the falling edge, return just after the next rising edge
    task automatic applyStimulus(input logic [7:0] w, input logic v);
        @(negedge clock);
        word_in    = w;
        word_valid = v;
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Send A then B, check the strobes, then four holdoff zeros
    task automatic sendPulse(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic exp_trig, input logic exp_mal,
                             input logic [3:0] exp_w, input logic [2:0] exp_o,
                             input logic exp_slip, input logic exp_aligned_after);
        applyStimulus(a, 1'b1);
        applyStimulus(b, 1'b1);
        checkOutput({tag, ".trigger"}, trigger, exp_trig);
        checkOutput({tag, ".malformed"}, malformed, exp_mal);
        checkOutput({tag, ".width"}, trigger_width, exp_w);
        checkOutput({tag, ".offset"}, trigger_offset, exp_o);
        checkOutput({tag, ".bitslip"}, bitslip, exp_slip);
        applyStimulus(8'h00, 1'b1);
        checkOutput({tag, ".aligned"}, aligned, exp_aligned_after);
        checkOutput({tag, ".strobe_clear"}, trigger | malformed | bitslip, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(8'h00, 1'b1);
    endtask

    // Linear directed sequence
    initial begin
        reset      = 1'b1;
        word_in    = 8'h00;
        word_valid = 1'b0;
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        reset = 1'b0;
        checkOutput("reset.trigger", trigger, 1'b0);
        checkOutput("reset.malformed", malformed, 1'b0);
        checkOutput("reset.aligned", aligned, 1'b0);
        checkOutput("reset.width", trigger_width, 4'd0);
        checkOutput("reset.tcount", trigger_count, 16'd0);
        checkOutput("reset.ecount", error_count, 16'd0);

        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        sendPulse("off0", 8'hFE, 8'h00, 1, 0, 4'd7, 3'd0, 0, 0);
        checkOutput("off0.tcount", trigger_count, 16'd1);
        sendPulse("straddle", 8'h0F, 8'hF0, 1, 0, 4'd8, 3'd4, 0, 0);
        sendPulse("twoRuns", 8'hA0, 8'h00, 0, 1, 4'd8, 3'd4, 0, 0);
        checkOutput("twoRuns.ecount", error_count, 16'd1);
        sendPulse("runNine", 8'hFF, 8'h80, 0, 1, 4'd8, 3'd4, 0, 0);
        sendPulse("lastBit", 8'h01, 8'h00, 1, 0, 4'd1, 3'd7, 0, 0);
        checkOutput("lastBit.tcount", trigger_count, 16'd3);
        checkOutput("lastBit.ecount", error_count, 16'd2);

        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("hold.trigger", trigger, 1'b1);
        checkOutput("hold.width", trigger_width, 4'd4);
        applyStimulus(8'h00, 1'b1);
        checkOutput("hold.quiet", malformed, 1'b0);
        applyStimulus(8'h01, 1'b1);
        checkOutput("hold.activity", malformed, 1'b1);
        checkOutput("hold.ecount", error_count, 16'd3);
        for (int k = 0; k < 3; k++) applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h40, 1'b1);
        checkOutput("hold.restart", malformed, 1'b1);
        checkOutput("hold.restartNoTrig", trigger, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(8'h00, 1'b1);
        sendPulse("afterHold", 8'h40, 8'h00, 1, 0, 4'd1, 3'd1, 0, 0);
        checkOutput("afterHold.ecount", error_count, 16'd4);

        for (int i = 0; i < 16; i++)
            sendPulse("slip", 8'h1C, 8'h00, 1, 0, 4'd3, 3'd3, (i == 15), 0);
        for (int i = 0; i < 16; i++)
            sendPulse("align", 8'hC0, 8'h00, 1, 0, 4'd2, 3'd0, 0, (i == 15));
        checkOutput("align.tcount", trigger_count, 16'd37);
        sendPulse("alignKeep", 8'hC0, 8'h00, 1, 0, 4'd2, 3'd0, 0, 1);
        sendPulse("alignDrop", 8'h1C, 8'h00, 1, 0, 4'd3, 3'd3, 0, 0);
        checkOutput("alignDrop.tcount", trigger_count, 16'd39);

        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h0F, 1'b1);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hF0, 1'b1);
        checkOutput("gap.trigger", trigger, 1'b1);
        checkOutput("gap.width", trigger_width, 4'd8);
        checkOutput("gap.offset", trigger_offset, 3'd4);
        checkOutput("gap.tcount", trigger_count, 16'd40);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h55, 1'b0);
        checkOutput("gap.invalidIgnored", malformed, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h40, 1'b1);
        checkOutput("gap.holdCount", malformed, 1'b1);
        checkOutput("gap.ecount", error_count, 16'd5);
        for (int k = 0; k < 4; k++) applyStimulus(8'h00, 1'b1);
        sendPulse("gapAfter", 8'hC0, 8'h00, 1, 0, 4'd2, 3'd0, 0, 0);
        checkOutput("gapAfter.tcount", trigger_count, 16'd41);

        applyStimulus(8'h0F, 1'b1);
        reset = 1'b1;
        applyStimulus(8'hF0, 1'b1);
        reset = 1'b0;
        checkOutput("rstCap.trigger", trigger, 1'b0);
        checkOutput("rstCap.malformed", malformed, 1'b0);
        checkOutput("rstCap.tcount", trigger_count, 16'd0);
        checkOutput("rstCap.ecount", error_count, 16'd0);
        checkOutput("rstCap.offset", trigger_offset, 3'd0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rstCap.noStrobe", trigger | malformed, 1'b0);
        sendPulse("rstAfter", 8'hF0, 8'h00, 1, 0, 4'd4, 3'd0, 0, 0);
        checkOutput("rstAfter.tcount", trigger_count, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_word_receiver.md
TRIGGER_WORD_RECEIVER -- requirements
Module: trigger_word_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: deserialized word width in bits; only 8 is supported.
REQ-002 SHALL have parameter HOLDOFF, default 4: number of all-zero valid words required after each evaluated pulse.
REQ-003 SHALL have parameter ALIGN_COUNT, default 16: consecutive well-formed triggers with equal offset needed for an alignment decision.
REQ-004 SHALL have port clock, input, 1: fabric word clock. There is one clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port word_in, input, WIDTH: deserialized word; word_in[7] is the earliest bit on the line.
REQ-007 SHALL have port word_valid, input, 1: word_in is valid this cycle.
REQ-008 SHALL have port trigger, output, 1: one-cycle strobe for a well-formed pulse.
REQ-009 SHALL have port trigger_width, output, 4: pulse length in bits, 1..8; valid while trigger is high.
REQ-010 SHALL have port trigger_offset, output, 3: leading-edge bit position, 0 = word_in[7]; valid while trigger is high.
REQ-011 SHALL have port malformed, output, 1: one-cycle strobe for a malformed pulse or for holdoff activity.
REQ-012 SHALL have port bitslip, output, 1: one-cycle request to the deserializer to slip by one bit.
REQ-013 SHALL have port aligned, output, 1: level; high while the latest ALIGN_COUNT consecutive well-formed triggers had offset 0.
REQ-014 SHALL have ports trigger_count and error_count, output, 16 each: saturating event counters.

Function
REQ-015 Words SHALL be consumed only on cycles with word_valid=1; with word_valid=0, state, counters and holdoff progress SHALL hold.
REQ-016 The FSM SHALL have three states: IDLE, CAPTURE, HOLDOFF.
REQ-017 IDLE SHALL register the first nonzero valid word as A and the leading-zero count of A as the offset, then go to CAPTURE.
REQ-018 CAPTURE SHALL register the next valid word as B and evaluate the 16-bit window W = {A,B} (A first).
REQ-019 The evaluation SHALL classify W as well-formed when W, starting at the offset, holds a single contiguous run of 1..8 ones and all remaining bits are zero.
REQ-020 Any other W SHALL be classified as malformed, including a run longer than 8 or a second run of ones.
REQ-021 trigger or malformed SHALL assert exactly one cycle after B is accepted, never both, then the FSM SHALL enter HOLDOFF.
REQ-022 HOLDOFF SHALL return to IDLE after HOLDOFF consecutive zero valid words.
REQ-023 In HOLDOFF, a nonzero valid word SHALL strobe malformed on the next cycle and restart the holdoff count.
REQ-024 trigger_count SHALL increment once per trigger; error_count SHALL increment once per malformed; both SHALL saturate at 16'hFFFF.
REQ-025 Alignment tracking: a streak counter SHALL increment on each well-formed trigger whose offset equals the previous well-formed trigger's offset, and reload to 1 otherwise.
REQ-026 Any malformed event SHALL clear the streak counter.
REQ-027 When the streak reaches ALIGN_COUNT with a nonzero offset, bitslip SHALL pulse for one cycle coincident with that trigger, and the streak SHALL clear.
REQ-028 When the streak reaches ALIGN_COUNT with offset 0, aligned SHALL go high the cycle after that trigger; it SHALL stay high until any trigger with a nonzero offset or any malformed event.
REQ-029 trigger_width and trigger_offset SHALL hold their last values between triggers.

Reset
REQ-030 While reset is high at a clock edge, the FSM SHALL go to IDLE and all outputs and counters SHALL be 0 on the next cycle.
REQ-031 A reset during CAPTURE or HOLDOFF SHALL discard the partial pulse without any strobe.
REQ-032 If reset and word_valid are high in the same cycle, that word SHALL be ignored.

Structure
REQ-033 A shared include SHALL hold the WIDTH default and the state encodings (IDLE=0, CAPTURE=1, HOLDOFF=2); it SHALL be used by this block and the transmit side.
REQ-034 A purely combinational sub-module, pulse_window_decoder, SHALL take W and the offset and return width and the well-formed flag.

Verification
REQ-035 Offset 0: idle zeros, then A=8'hFE, B=8'h00 -> trigger=1, trigger_width=7, trigger_offset=0, trigger_count=1.
REQ-036 Straddling pulse: A=8'h0F, B=8'hF0 -> trigger=1, trigger_width=8, trigger_offset=4.
REQ-037 Malformed pulse: A=8'hA0, B=8'h00 -> malformed=1, error_count=1, no trigger.
REQ-038 Holdoff activity: after a valid trigger, 8'h01 as the 2nd holdoff word -> malformed=1, then 4 further zeros are needed before IDLE.
REQ-039 Alignment: 16 well-formed triggers at offset 3 -> a single bitslip pulse on the 16th trigger; next 16 triggers at offset 0 -> aligned=1.
REQ-040 Reset and gating: assert reset during CAPTURE -> no strobe and all counts 0; word_valid=0 gaps inside a pulse -> results identical to the gap-free run.
